// File: rtl/imm_pkg.sv
// Shared types, opcode constants and helpers for the immediate decode pipeline.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_U    = 3'd0,
        FMT_J    = 3'd1,
        FMT_B    = 3'd2,
        FMT_I    = 3'd3,
        FMT_S    = 3'd4,
        FMT_R    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_NONE = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // Replicate value[msb] into every bit from msb upward.
    function automatic logic [31:0] sext(input logic [31:0] value, input logic [4:0] msb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << msb;
        return value[msb] ? (value | mask) : (value & ~mask);
    endfunction

endpackage

// File: rtl/imm_decode_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the immediate decode pipeline.
interface imm_decode_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    imm_fmt_e         out_fmt;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_target;
    logic             out_illegal;
    logic             cnt_clr;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, in_instr, in_pc, out_ready, cnt_clr,
        input  in_ready, out_valid, out_fmt, out_imm, out_target, out_illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, cnt_clr,
        output in_ready, out_valid, out_fmt, out_imm, out_target, out_illegal, illegal_cnt
    );
endinterface

// File: rtl/imm_extract.sv
// Combinational RV instruction classifier and immediate extractor.
// IMM_GEN_CSR_ZIMM_EN selects the zero-extended CSR immediate (format Z) for CSRR*I.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output imm_fmt_e        fmt_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);
    logic [31:0] imm32;

    always_comb begin
        fmt_o     = FMT_NONE;
        imm32     = '0;
        illegal_o = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (instr_i[6:0])
                OPC_LUI, OPC_AUIPC: begin
                    fmt_o = FMT_U;
                    imm32 = {instr_i[31:12], 12'b0};
                end
                OPC_JAL: begin
                    fmt_o = FMT_J;
                    imm32 = sext({11'b0, instr_i[31], instr_i[19:12], instr_i[20],
                                  instr_i[30:21], 1'b0}, 5'd20);
                end
                OPC_BRANCH: begin
                    fmt_o = FMT_B;
                    imm32 = sext({19'b0, instr_i[31], instr_i[7], instr_i[30:25],
                                  instr_i[11:8], 1'b0}, 5'd12);
                end
                OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM: begin
                    fmt_o = FMT_I;
                    imm32 = sext({20'b0, instr_i[31:20]}, 5'd11);
                end
                OPC_SYSTEM: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
                    if (instr_i[14]) begin
                        fmt_o = FMT_Z;
                        imm32 = {27'b0, instr_i[19:15]};
                    end else begin
                        fmt_o = FMT_I;
                        imm32 = sext({20'b0, instr_i[31:20]}, 5'd11);
                    end
`else
                    fmt_o = FMT_I;
                    imm32 = sext({20'b0, instr_i[31:20]}, 5'd11);
`endif
                end
                OPC_STORE: begin
                    fmt_o = FMT_S;
                    imm32 = sext({20'b0, instr_i[31:25], instr_i[11:7]}, 5'd11);
                end
                OPC_OP: fmt_o = FMT_R;
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) begin
                        fmt_o = FMT_I;
                        imm32 = sext({20'b0, instr_i[31:20]}, 5'd11);
                    end else begin
                        illegal_o = 1'b1;
                    end
                end
                OPC_OP_32: begin
                    if (XLEN == 64) fmt_o = FMT_R;
                    else            illegal_o = 1'b1;
                end
                default: illegal_o = 1'b1;
            endcase
        end
    end

    // Z immediates have bit 31 clear, so a signed widen also zero-extends them.
    assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/imm_decode_pipe.sv
// Two-stage immediate decoder: S1 classifies and extracts, S2 forms pc+imm, with a
// saturating illegal-instruction counter. Optional macro: IMM_GEN_CSR_ZIMM_EN.
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    imm_decode_pipe_if.slave bus
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_pipe: XLEN must be 32 or 64");
    end

    imm_fmt_e         ex_fmt;
    logic [XLEN-1:0]  ex_imm;
    logic             ex_ill;

    logic             s1_v_q, s1_v_d, s1_ill_q, s1_ill_d;
    imm_fmt_e         s1_fmt_q, s1_fmt_d;
    logic [XLEN-1:0]  s1_imm_q, s1_imm_d, s1_pc_q, s1_pc_d;

    logic             s2_v_q, s2_v_d, s2_ill_q, s2_ill_d;
    imm_fmt_e         s2_fmt_q, s2_fmt_d;
    logic [XLEN-1:0]  s2_imm_q, s2_imm_d, s2_tgt_q, s2_tgt_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s2_free, s1_free, accept;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr_i   (bus.in_instr),
        .fmt_o     (ex_fmt),
        .imm_o     (ex_imm),
        .illegal_o (ex_ill)
    );

    always_comb begin
        s2_free  = !s2_v_q || bus.out_ready;
        s1_free  = !s1_v_q || s2_free;
        accept   = bus.in_valid && s1_free;

        s1_v_d   = s1_v_q;
        s1_fmt_d = s1_fmt_q;
        s1_imm_d = s1_imm_q;
        s1_pc_d  = s1_pc_q;
        s1_ill_d = s1_ill_q;
        s2_v_d   = s2_v_q;
        s2_fmt_d = s2_fmt_q;
        s2_imm_d = s2_imm_q;
        s2_tgt_d = s2_tgt_q;
        s2_ill_d = s2_ill_q;
        cnt_d    = cnt_q;

        if (s1_free) begin
            s1_v_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_fmt_d = ex_fmt;
                s1_imm_d = ex_imm;
                s1_pc_d  = bus.in_pc;
                s1_ill_d = ex_ill;
            end
        end

        // Output registers only change when empty or being consumed, which keeps them stable under stall.
        if (s2_free) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_fmt_d = s1_fmt_q;
                s2_imm_d = s1_imm_q;
                s2_tgt_d = s1_pc_q + s1_imm_q;
                s2_ill_d = s1_ill_q;
            end
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (accept && ex_ill && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_fmt_q <= FMT_U;
            s1_imm_q <= '0;
            s1_pc_q  <= '0;
            s1_ill_q <= 1'b0;
            s2_v_q   <= 1'b0;
            s2_fmt_q <= FMT_U;
            s2_imm_q <= '0;
            s2_tgt_q <= '0;
            s2_ill_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_fmt_q <= s1_fmt_d;
            s1_imm_q <= s1_imm_d;
            s1_pc_q  <= s1_pc_d;
            s1_ill_q <= s1_ill_d;
            s2_v_q   <= s2_v_d;
            s2_fmt_q <= s2_fmt_d;
            s2_imm_q <= s2_imm_d;
            s2_tgt_q <= s2_tgt_d;
            s2_ill_q <= s2_ill_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready    = s1_free;
    assign bus.out_valid   = s2_v_q;
    assign bus.out_fmt     = s2_fmt_q;
    assign bus.out_imm     = s2_imm_q;
    assign bus.out_target  = s2_tgt_q;
    assign bus.out_illegal = s2_ill_q;
    assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: directed vector table, 64-bit corner cases, counter
// saturation/clear, stall stream, randomized traffic against a reference model, mid-stream reset.
module tb_imm_decode_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_decode_pipe_if #(.XLEN(32), .CNT_W(16)) b32 ();
    imm_decode_pipe_if #(.XLEN(64), .CNT_W(2))  b64 ();

    imm_decode_pipe #(.XLEN(32), .CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_decode_pipe #(.XLEN(64), .CNT_W(2))  dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        ill;
    } dec_t;

    // Reference decode: field values as integers, sign applied by subtracting 2^width.
    function automatic dec_t model(input logic [31:0] ins, input bit rv64);
        dec_t   d;
        longint v;
        bit     legal;
        v = 0; legal = 1'b1; d.fmt = FMT_NONE;
        case (ins[6:0])
            7'h37, 7'h17: begin
                d.fmt = FMT_U; v = ins[31:12]; v = v * 4096;
                if (ins[31]) v -= (longint'(1) << 32);
            end
            7'h6F: begin
                d.fmt = FMT_J; v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                if (ins[31]) v -= (longint'(1) << 21);
            end
            7'h63: begin
                d.fmt = FMT_B; v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                if (ins[31]) v -= 8192;
            end
            7'h67, 7'h03, 7'h13, 7'h0F: begin
                d.fmt = FMT_I; v = ins[31:20]; if (ins[31]) v -= 4096;
            end
            7'h73: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
                if (ins[14]) begin
                    d.fmt = FMT_Z; v = ins[19:15];
                end else begin
                    d.fmt = FMT_I; v = ins[31:20]; if (ins[31]) v -= 4096;
                end
`else
                d.fmt = FMT_I; v = ins[31:20]; if (ins[31]) v -= 4096;
`endif
            end
            7'h23: begin
                d.fmt = FMT_S; v = {ins[31:25], ins[11:7]}; if (ins[31]) v -= 4096;
            end
            7'h33: d.fmt = FMT_R;
            7'h1B: begin
                if (rv64) begin d.fmt = FMT_I; v = ins[31:20]; if (ins[31]) v -= 4096; end
                else legal = 1'b0;
            end
            7'h3B: begin
                if (rv64) d.fmt = FMT_R;
                else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin d.fmt = FMT_NONE; v = 0; end
        d.imm = 64'(v);
        d.ill = !legal;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 15))
            0:  r[6:0] = 7'h37;
            1:  r[6:0] = 7'h17;
            2:  r[6:0] = 7'h6F;
            3:  r[6:0] = 7'h67;
            4:  r[6:0] = 7'h63;
            5:  r[6:0] = 7'h03;
            6:  r[6:0] = 7'h23;
            7:  r[6:0] = 7'h13;
            8:  r[6:0] = 7'h33;
            9:  r[6:0] = 7'h0F;
            10: r[6:0] = 7'h73;
            11: r[6:0] = 7'h1B;
            12: r[6:0] = 7'h3B;
            13: begin r[6:0] = 7'h73; r[14] = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    // ---------------- scoreboard on the 32-bit instance ----------------
    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    bit          sb_en = 1'b0;
    int          pops = 0;
    int          exp_ill_cnt = 0;
    bit          hold_v = 1'b0;
    logic [2:0]  h_fmt;
    logic [31:0] h_imm, h_tgt;
    logic        h_ill;

    always @(negedge clk) begin
        dec_t d;
        exp_t e;
        if (sb_en && rst_n) begin
            if (hold_v) begin
                chk("hold_data", {b32.out_imm, b32.out_target}, {h_imm, h_tgt});
                chk("hold_ctl", {b32.out_valid, b32.out_fmt, b32.out_illegal}, {1'b1, h_fmt, h_ill});
            end
            chk("in_ready", b32.in_ready, !(q.size() == 2 && !b32.out_ready));
            if (b32.out_valid && b32.out_ready) begin
                chk("sb_nonempty", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_data", {b32.out_imm, b32.out_target}, {e.imm, e.tgt});
                    chk("sb_ctl", {b32.out_fmt, b32.out_illegal}, {e.fmt, e.ill});
                    pops++;
                end
            end
            if (b32.in_valid && b32.in_ready) begin
                d = model(b32.in_instr, 1'b0);
                e.fmt = d.fmt;
                e.imm = d.imm[31:0];
                e.tgt = b32.in_pc + d.imm[31:0];
                e.ill = d.ill;
                if (d.ill) exp_ill_cnt++;
                q.push_back(e);
            end
            hold_v = b32.out_valid && !b32.out_ready;
            h_fmt  = b32.out_fmt;
            h_imm  = b32.out_imm;
            h_tgt  = b32.out_target;
            h_ill  = b32.out_illegal;
        end else begin
            hold_v = 1'b0;
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        ill;
        string       name;
    } vec_t;

    vec_t vt[12];

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        b32.in_valid = 1'b1; b32.in_instr = v.instr; b32.in_pc = v.pc; b32.out_ready = 1'b1;
        chk({v.name, "/in_ready"}, b32.in_ready, 1'b1);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        chk({v.name, "/early"}, b32.out_valid, 1'b0);
        lat = 1;
        while (!b32.out_valid && lat < 8) begin @(posedge clk); #1; lat++; end
        chk({v.name, "/latency"}, lat, 2);
        chk({v.name, "/fmt"}, b32.out_fmt, v.fmt);
        chk({v.name, "/imm"}, b32.out_imm, v.imm);
        chk({v.name, "/target"}, b32.out_target, v.tgt);
        chk({v.name, "/illegal"}, b32.out_illegal, v.ill);
    endtask

    task automatic run64(input string name, input logic [31:0] ins, input logic [63:0] pc,
                         input logic [2:0] efmt, input logic [63:0] eimm, input logic [63:0] etgt,
                         input logic eill);
        int lat;
        @(negedge clk);
        b64.in_valid = 1'b1; b64.in_instr = ins; b64.in_pc = pc; b64.out_ready = 1'b1;
        @(posedge clk); #1;
        b64.in_valid = 1'b0;
        lat = 1;
        while (!b64.out_valid && lat < 8) begin @(posedge clk); #1; lat++; end
        chk({name, "/latency"}, lat, 2);
        chk({name, "/fmt"}, b64.out_fmt, efmt);
        chk({name, "/imm"}, b64.out_imm, eimm);
        chk({name, "/target"}, b64.out_target, etgt);
        chk({name, "/illegal"}, b64.out_illegal, eill);
    endtask

    logic [31:0] stream[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx, cyc, n, pops0;
        bit  acc, saw_stall;

        vt[0]  = '{instr:32'hFFF00093, pc:32'h0,    fmt:FMT_I,    imm:32'hFFFFFFFF, tgt:32'hFFFFFFFF, ill:1'b0, name:"addi_m1"};
        vt[1]  = '{instr:32'hFE000EE3, pc:32'h100,  fmt:FMT_B,    imm:32'hFFFFFFFC, tgt:32'h000000FC, ill:1'b0, name:"beq_m4"};
        vt[2]  = '{instr:32'h123450B7, pc:32'h1000, fmt:FMT_U,    imm:32'h12345000, tgt:32'h12346000, ill:1'b0, name:"lui"};
        vt[3]  = '{instr:32'h0000003B, pc:32'h20,   fmt:FMT_NONE, imm:32'h0,        tgt:32'h20,       ill:1'b1, name:"op32_rv32"};
`ifdef IMM_GEN_CSR_ZIMM_EN
        vt[4]  = '{instr:32'h300FD073, pc:32'h0,    fmt:FMT_Z,    imm:32'h1F,       tgt:32'h1F,       ill:1'b0, name:"csrrwi"};
`else
        vt[4]  = '{instr:32'h300FD073, pc:32'h0,    fmt:FMT_I,    imm:32'h300,      tgt:32'h300,      ill:1'b0, name:"csrrwi"};
`endif
        vt[5]  = '{instr:32'h00000000, pc:32'h44,   fmt:FMT_NONE, imm:32'h0,        tgt:32'h44,       ill:1'b1, name:"zero_word"};
        vt[6]  = '{instr:32'h008000EF, pc:32'h40,   fmt:FMT_J,    imm:32'h8,        tgt:32'h48,       ill:1'b0, name:"jal_8"};
        vt[7]  = '{instr:32'hFE20AC23, pc:32'h10,   fmt:FMT_S,    imm:32'hFFFFFFF8, tgt:32'h8,        ill:1'b0, name:"sw_m8"};
        vt[8]  = '{instr:32'h002081B3, pc:32'h55,   fmt:FMT_R,    imm:32'h0,        tgt:32'h55,       ill:1'b0, name:"add"};
        vt[9]  = '{instr:32'hFFFFF117, pc:32'h2000, fmt:FMT_U,    imm:32'hFFFFF000, tgt:32'h1000,     ill:1'b0, name:"auipc_neg"};
        vt[10] = '{instr:32'h0000007F, pc:32'h8,    fmt:FMT_NONE, imm:32'h0,        tgt:32'h8,        ill:1'b1, name:"bad_opc"};
        vt[11] = '{instr:32'h7FF0A083, pc:32'h1,    fmt:FMT_I,    imm:32'h7FF,      tgt:32'h800,      ill:1'b0, name:"lw_2047"};

        stream = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h0000003B, 32'h00000000, 32'h008000EF};

        b32.in_valid = 0; b32.in_instr = 0; b32.in_pc = 0; b32.out_ready = 0; b32.cnt_clr = 0;
        b64.in_valid = 0; b64.in_instr = 0; b64.in_pc = 0; b64.out_ready = 0; b64.cnt_clr = 0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst/out_valid", b32.out_valid, 1'b0);
        chk("rst/in_ready", b32.in_ready, 1'b1);
        chk("rst/cnt", b32.illegal_cnt, 0);
        chk("rst/data", {b32.out_fmt, b32.out_imm, b32.out_target}, 0);
        chk("rst64/out_valid", b64.out_valid, 1'b0);
        chk("rst64/cnt", b64.illegal_cnt, 0);

        for (int i = 0; i < 12; i++) run_vec(vt[i]);

        run64("beq64", 32'hFE000EE3, 64'h100, FMT_B, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFC, 1'b0);
        run64("op32_rv64", 32'h0000003B, 64'h8000_0000_0000_0000, FMT_R, 64'h0, 64'h8000_0000_0000_0000, 1'b0);
        run64("addiw_m1", 32'hFFF0009B, 64'h1, FMT_I, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
        run64("lui64", 32'h123450B7, 64'hFFFF_FFFF_FFFF_F000, FMT_U, 64'h12345000, 64'h12344000, 1'b0);
        run64("lui64_neg", 32'h80000037, 64'h0, FMT_U, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);

        // Counter saturation and clear priority on the 2-bit counter
        @(posedge clk); #1;
        b64.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b64.in_valid = 1'b1; b64.in_instr = 32'h0;
            @(negedge clk);
            chk("cnt/in_ready", b64.in_ready, 1'b1);
            @(posedge clk); #1;
            chk("cnt/sat", b64.illegal_cnt, (k + 1 > 3) ? 3 : k + 1);
        end
        b64.cnt_clr = 1'b1;
        @(posedge clk); #1;
        chk("cnt/clr_wins", b64.illegal_cnt, 0);
        b64.cnt_clr = 1'b0;
        @(posedge clk); #1;
        chk("cnt/after_clr", b64.illegal_cnt, 1);
        b64.in_instr = 32'h00000013;
        @(posedge clk); #1;
        chk("cnt/legal_noinc", b64.illegal_cnt, 1);
        b64.in_valid = 1'b0;

        // Stall stream: six instructions, consumer stalls in cycles 3..5
        repeat (3) @(posedge clk);
        #1;
        sb_en = 1'b1;
        idx = 0; cyc = 0; saw_stall = 0; pops0 = pops;
        while ((idx < 6 || q.size() > 0) && cyc < 40) begin
            b32.in_valid = (idx < 6);
            if (idx < 6) begin b32.in_instr = stream[idx]; b32.in_pc = 32'h400 + 32'(idx * 4); end
            b32.out_ready = !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            if (!b32.in_ready) saw_stall = 1;
            acc = b32.in_valid && b32.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        b32.in_valid = 1'b0;
        chk("stream/no_timeout", cyc < 40, 1'b1);
        chk("stream/in_ready_dropped", saw_stall, 1'b1);
        chk("stream/count", pops - pops0, 6);

        // Randomized traffic
        sb_en = 1'b0;
        b32.cnt_clr = 1'b1;
        @(posedge clk); #1;
        b32.cnt_clr = 1'b0;
        exp_ill_cnt = 0;
        q.delete();
        sb_en = 1'b1;
        repeat (400) begin
            b32.in_valid  = ($urandom_range(0, 9) < 7);
            b32.in_instr  = rand_instr();
            b32.in_pc     = $urandom();
            b32.out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk); #1;
        end
        b32.in_valid = 1'b0; b32.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
        chk("rand/drained", q.size(), 0);
        chk("rand/illegal_cnt", b32.illegal_cnt, exp_ill_cnt);
        sb_en = 1'b0;

        // Mid-stream reset
        @(posedge clk); #1;
        b32.out_ready = 1'b0; b32.in_valid = 1'b1; b32.in_instr = 32'h0;
        @(posedge clk); #1;
        b32.in_instr = 32'hFFF00093; b32.in_pc = 32'h7;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        chk("midrst/pre_valid", b32.out_valid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst/out_valid", b32.out_valid, 1'b0);
        chk("midrst/data", {b32.out_imm, b32.out_target}, 0);
        chk("midrst/cnt", b32.illegal_cnt, 0);
        rst_n = 1'b1;
        chk("midrst/in_ready", b32.in_ready, 1'b1);
        @(posedge clk); #1;
        chk("midrst/no_ghost", b32.out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
